// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional subtract mode is compiled in with the SUB_EN macro.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               sub_sel;
    logic               fa_sum;
    logic               fa_cout;

`ifdef SUB_EN
    assign sub_sel = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_sel    = 1'b0;
`endif

    // Shared 1-bit full-adder datapath cell.
    assign fa_sum  = sa[0] ^ sb[0] ^ carry;
    assign fa_cout = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand shifters, carry, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= sub_sel ? ~b : b;
                        carry <= sub_sel;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                end
                DONE: begin
                    sum   <= res;
                    c_out <= carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): random and directed operations
// checked against an arithmetic reference model, with latency and hold checks.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           due;
    } exp_t;

    exp_t sbq[$];

    logic [W-1:0] held_sum;
    logic         held_c;
    int           busy_cnt;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y};
`ifdef SUB_EN
        if (s) r = {(x >= y), W'(x - y)};
`else
        if (s) r = {1'b0, x} + {1'b0, y};
`endif
        return r;
    endfunction

    // Monitor: pops the scoreboard on done, checks hold behaviour otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst) begin
                held_sum = '0;
                held_c   = 1'b0;
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                    end else begin
                        e = sbq.pop_front();
                        check("sum", 32'(sum), 32'(e.s));
                        check("c_out", 32'(c_out), 32'(e.c));
                        check("done_latency", 32'(cyc), 32'(e.due));
                        check("busy_cycles", 32'(busy_cnt), 32'(W));
                        held_sum = e.s;
                        held_c   = e.c;
                    end
                    busy_cnt = 0;
                end else begin
                    check("sum_hold", 32'(sum), 32'(held_sum));
                    check("c_out_hold", 32'(c_out), 32'(held_c));
                    if (sbq.size() != 0 && cyc > sbq[0].due) begin
                        e = sbq.pop_front();
                        checks++;
                        errors++;
                        $display("FAIL done_timeout: got no done expected done by cycle %0d", e.due);
                    end
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        logic [W:0] r;
        exp_t e;
        @(posedge clk); #1;
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        r = model(ta, tb_v, ts);
        e.s = r[W-1:0];
        e.c = r[W];
        e.due = cyc + W + 1;
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        held_sum = '0; held_c = 1'b0; busy_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        mon_en = 1'b1;

        do_op(8'h35, 8'h4A, 1'b0); wait_idle();
        do_op(8'hFF, 8'h01, 1'b0); wait_idle();
        do_op(8'h00, 8'h00, 1'b0); wait_idle();
        do_op(8'hFF, 8'hFF, 1'b0); wait_idle();

        // Start pulse in the middle of RUN must be ignored.
        do_op(8'h35, 8'h4A, 1'b0);
        repeat (3) @(posedge clk);
        #1 a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();
        repeat (W + 4) @(posedge clk);
        #1;

        // Reset mid-operation aborts without a done pulse.
        do_op(8'hA5, 8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        do_op(8'h10, 8'h20, 1'b0); wait_idle();

        do_op(8'h20, 8'h05, 1'b1); wait_idle();
        do_op(8'h05, 8'h20, 1'b1); wait_idle();
        do_op(8'h33, 8'h33, 1'b1); wait_idle();

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_idle();
        end

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
